// File: rtl/riscv_pkg.sv
// Shared opcode constants, ALU operation encoding and the canonical NOP for the RV32I-subset core.
package riscv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_MUL,
        ALU_PASSB
    } alu_op_e;

endpackage

// File: rtl/riscv_alu.sv
// Combinational ALU with compare flags; the MUL operation exists only when RV_MUL_EN is defined.
// Latency: zero cycles, purely combinational.
// Backpressure: none; outputs follow the inputs.
import riscv_pkg::*;

module riscv_alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     alu_op,
    output logic [31:0] y,
    output logic        zero,
    output logic        lt,
    output logic        ltu
);

    assign lt  = $signed(a) < $signed(b);
    assign ltu = a < b;

    always_comb begin
        y = '0;
        case (alu_op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_SLT:   y = {31'b0, lt};
            ALU_SLTU:  y = {31'b0, ltu};
            ALU_SLL:   y = a << b[4:0];
            ALU_SRL:   y = a >> b[4:0];
            ALU_SRA:   y = $signed(a) >>> b[4:0];
`ifdef RV_MUL_EN
            ALU_MUL:   y = a * b;
`endif
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

    // Branches compare with ALU_SUB, so zero doubles as the equality flag.
    assign zero = (y == '0);

endmodule

// File: rtl/riscv_processor.sv
// Single-cycle RV32I-subset core with internal ROM/RAM; MUL is added when RV_MUL_EN is defined.
// Latency: every instruction commits write-back, store and pc update on the clk edge ending its cycle.
// Backpressure: none; no external bus, the core never stalls.
import riscv_pkg::*;

module riscv_processor #(
    parameter int    IMEM_DEPTH = 64,
    parameter int    DMEM_DEPTH = 64,
    parameter string IMEM_FILE  = "program.hex",
    parameter int    RESULT_REG = 10
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] result
);

    localparam int         IAW     = $clog2(IMEM_DEPTH);
    localparam int         DAW     = $clog2(DMEM_DEPTH);
    localparam logic [4:0] RES_IDX = 5'(RESULT_REG);

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
    typedef enum logic [1:0] {PC_SEQ, PC_BR, PC_JAL, PC_JALR} pc_sel_e;

    // Zero initialisers let the core run correctly from time 0 without a reset pulse.
    logic [31:0] pc = '0;
    logic [31:0] regs [32] = '{default: '0};
    logic [31:0] imem [IMEM_DEPTH] = '{default: NOP};
    logic [31:0] dmem [DMEM_DEPTH] = '{default: '0};

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic [31:0] pc_plus4;

    assign instr    = imem[pc[IAW+1:2]];
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7   = instr[31:25];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {instr[31:12], 12'b0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign rv1      = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rv2      = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign pc_plus4 = pc + 32'd4;

    alu_op_e     alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        alu_lt;
    logic        alu_ltu;
    logic        reg_we;
    logic        mem_we;
    wb_sel_e     wb_sel;
    pc_sel_e     pc_sel;

    // Decode: anything not matched exactly stays at the defaults, i.e. behaves as a NOP.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = rv1;
        alu_b  = rv2;
        reg_we = 1'b0;
        mem_we = 1'b0;
        wb_sel = WB_ALU;
        pc_sel = PC_SEQ;
        case (opcode)
            OP: begin
                reg_we = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'd0}: alu_op = ALU_ADD;
                    {7'h20, 3'd0}: alu_op = ALU_SUB;
                    {7'h00, 3'd1}: alu_op = ALU_SLL;
                    {7'h00, 3'd2}: alu_op = ALU_SLT;
                    {7'h00, 3'd3}: alu_op = ALU_SLTU;
                    {7'h00, 3'd4}: alu_op = ALU_XOR;
                    {7'h00, 3'd5}: alu_op = ALU_SRL;
                    {7'h20, 3'd5}: alu_op = ALU_SRA;
                    {7'h00, 3'd6}: alu_op = ALU_OR;
                    {7'h00, 3'd7}: alu_op = ALU_AND;
`ifdef RV_MUL_EN
                    {7'h01, 3'd0}: alu_op = ALU_MUL;
`endif
                    default:       reg_we = 1'b0;
                endcase
            end
            OP_IMM: begin
                alu_b  = imm_i;
                reg_we = 1'b1;
                case (funct3)
                    3'd0: alu_op = ALU_ADD;
                    3'd2: alu_op = ALU_SLT;
                    3'd3: alu_op = ALU_SLTU;
                    3'd4: alu_op = ALU_XOR;
                    3'd6: alu_op = ALU_OR;
                    3'd7: alu_op = ALU_AND;
                    3'd1: begin
                        alu_op = ALU_SLL;
                        reg_we = (funct7 == 7'h00);
                    end
                    default: begin
                        alu_op = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                        reg_we = (funct7 == 7'h00) || (funct7 == 7'h20);
                    end
                endcase
            end
            LOAD: begin
                alu_b  = imm_i;
                reg_we = (funct3 == 3'd2);
                wb_sel = WB_MEM;
            end
            STORE: begin
                alu_b  = imm_s;
                mem_we = (funct3 == 3'd2);
            end
            BRANCH: begin
                alu_op = ALU_SUB;
                if (funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd4 || funct3 == 3'd5)
                    pc_sel = PC_BR;
            end
            JAL: begin
                reg_we = 1'b1;
                wb_sel = WB_PC4;
                pc_sel = PC_JAL;
            end
            JALR: begin
                alu_b = imm_i;
                if (funct3 == 3'd0) begin
                    reg_we = 1'b1;
                    wb_sel = WB_PC4;
                    pc_sel = PC_JALR;
                end
            end
            LUI: begin
                alu_op = ALU_PASSB;
                alu_b  = imm_u;
                reg_we = 1'b1;
            end
            AUIPC: begin
                alu_a  = pc;
                alu_b  = imm_u;
                reg_we = 1'b1;
            end
            default: ;
        endcase
    end

    riscv_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .alu_op (alu_op),
        .y      (alu_y),
        .zero   (alu_zero),
        .lt     (alu_lt),
        .ltu    (alu_ltu)
    );

    logic        br_take;
    logic [31:0] pc_next;
    logic [31:0] mem_rdat;
    logic [31:0] wb_dat;

    assign mem_rdat = dmem[alu_y[DAW+1:2]];

    // Unsigned compares resolve here as well, but decode never selects PC_BR for them.
    always_comb begin
        br_take = 1'b0;
        case (funct3)
            3'd0:    br_take = alu_zero;
            3'd1:    br_take = !alu_zero;
            3'd4:    br_take = alu_lt;
            3'd5:    br_take = !alu_lt;
            3'd6:    br_take = alu_ltu;
            3'd7:    br_take = !alu_ltu;
            default: br_take = 1'b0;
        endcase
    end

    always_comb begin
        pc_next = pc_plus4;
        case (pc_sel)
            PC_BR:   if (br_take) pc_next = pc + imm_b;
            PC_JAL:  pc_next = pc + imm_j;
            PC_JALR: pc_next = alu_y & ~32'd1;
            default: pc_next = pc_plus4;
        endcase
        case (wb_sel)
            WB_MEM:  wb_dat = mem_rdat;
            WB_PC4:  wb_dat = pc_plus4;
            default: wb_dat = alu_y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else begin
            pc <= pc_next;
            if (reg_we && rd != 5'd0) regs[rd] <= wb_dat;
        end
    end

    // Data memory keeps its contents across reset; only stores from running code change it.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) dmem[alu_y[DAW+1:2]] <= rv2;
    end

    assign result = regs[RES_IDX][15:0];

endmodule

// File: tb/tb_riscv_processor.sv
// Bench for riscv_processor: directed programs plus random programs checked against an ISA-level model.
module tb_riscv_processor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] result;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_rom [64];
    logic [31:0] m_mem [64];
    logic [31:0] m_x   [32];
    logic [31:0] m_pc;

    riscv_processor #(.IMEM_FILE("")) dut (
        .clk    (clk),
        .reset  (reset),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] e_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] e_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] e_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] e_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [11:0] imm;
        logic [3:0]  r4;
        logic [2:0]  f3;
        logic [6:0]  f7;
        imm = 12'($urandom);
        r4  = 4'($urandom);
        f3  = 3'($urandom);
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 13))
            0, 1, 2: return e_r(f7, rreg(), rreg(), f3, rreg(), 7'h33);
            3, 4, 5: return e_i((f3 == 3'd1 || f3 == 3'd5) ? {f7, imm[4:0]} : imm, rreg(), f3, rreg(), 7'h13);
            6:       return e_u(20'($urandom), rreg(), 7'h37);
            7:       return e_u(20'($urandom), rreg(), 7'h17);
            8:       return e_s(imm, rreg(), rreg(), ($urandom_range(0, 3) == 0) ? f3 : 3'd2);
            9:       return e_i(imm, rreg(), ($urandom_range(0, 3) == 0) ? f3 : 3'd2, rreg(), 7'h03);
            10:      return e_b({{7{r4[3]}}, r4, 2'b00}, rreg(), rreg(), f3);
            11:      return e_j({{15{r4[3]}}, r4, 2'b00}, rreg());
            12:      return e_i(imm, rreg(), ($urandom_range(0, 3) == 0) ? f3 : 3'd0, rreg(), 7'h67);
            default: return $urandom;
        endcase
    endfunction

    // Instruction-set level reference: one call retires one instruction.
    task automatic m_step();
        logic [31:0] ins, a, b, ii, si, bi, ui, ji, ea, v, npc;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        wr, tk;
        ins = m_rom[m_pc[7:2]];
        op  = ins[6:0];
        rd  = ins[11:7];
        f3  = ins[14:12];
        f7  = ins[31:25];
        a   = m_x[ins[19:15]];
        b   = m_x[ins[24:20]];
        ii  = {{20{ins[31]}}, ins[31:20]};
        si  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        bi  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ui  = {ins[31:12], 12'b0};
        ji  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        npc = m_pc + 32'd4;
        v   = '0;
        wr  = 1'b0;
        tk  = 1'b0;
        case (op)
            7'h33: begin
                wr = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'd0}: v = a + b;
                    {7'h20, 3'd0}: v = a - b;
                    {7'h00, 3'd1}: v = a << b[4:0];
                    {7'h00, 3'd2}: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    {7'h00, 3'd3}: v = (a < b) ? 32'd1 : 32'd0;
                    {7'h00, 3'd4}: v = a ^ b;
                    {7'h00, 3'd5}: v = a >> b[4:0];
                    {7'h20, 3'd5}: v = $signed(a) >>> b[4:0];
                    {7'h00, 3'd6}: v = a | b;
                    {7'h00, 3'd7}: v = a & b;
`ifdef RV_MUL_EN
                    {7'h01, 3'd0}: v = a * b;
`endif
                    default:       wr = 1'b0;
                endcase
            end
            7'h13: begin
                wr = 1'b1;
                case (f3)
                    3'd0: v = a + ii;
                    3'd2: v = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
                    3'd3: v = (a < ii) ? 32'd1 : 32'd0;
                    3'd4: v = a ^ ii;
                    3'd6: v = a | ii;
                    3'd7: v = a & ii;
                    3'd1: if (f7 == 7'h00) v = a << ii[4:0]; else wr = 1'b0;
                    default: begin
                        if (f7 == 7'h00)      v = a >> ii[4:0];
                        else if (f7 == 7'h20) v = $signed(a) >>> ii[4:0];
                        else                  wr = 1'b0;
                    end
                endcase
            end
            7'h03: if (f3 == 3'd2) begin
                ea = a + ii;
                v  = m_mem[ea[7:2]];
                wr = 1'b1;
            end
            7'h23: if (f3 == 3'd2) begin
                ea = a + si;
                m_mem[ea[7:2]] = b;
            end
            7'h63: begin
                case (f3)
                    3'd0:    tk = (a == b);
                    3'd1:    tk = (a != b);
                    3'd4:    tk = ($signed(a) < $signed(b));
                    3'd5:    tk = ($signed(a) >= $signed(b));
                    default: tk = 1'b0;
                endcase
                if (tk) npc = m_pc + bi;
            end
            7'h6f: begin
                v   = m_pc + 32'd4;
                wr  = 1'b1;
                npc = m_pc + ji;
            end
            7'h67: if (f3 == 3'd0) begin
                v   = m_pc + 32'd4;
                wr  = 1'b1;
                npc = (a + ii) & ~32'd1;
            end
            7'h37: begin v = ui;        wr = 1'b1; end
            7'h17: begin v = m_pc + ui; wr = 1'b1; end
            default: ;
        endcase
        if (wr && rd != 5'd0) m_x[rd] = v;
        m_pc = npc;
    endtask

    task automatic m_reset();
        m_pc = '0;
        for (int i = 0; i < 32; i++) m_x[i] = '0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) m_rom[i] = 32'h0000_0013;
    endtask

    task automatic commit_rom();
        for (int i = 0; i < 64; i++) dut.imem[i] = m_rom[i];
    endtask

    // One clock edge in lockstep: DUT result and pc against the model.
    task automatic step(input string tag);
        @(posedge clk);
        m_step();
        #1;
        chk({tag, "_res"}, {16'h0, result}, {16'h0, m_x[10][15:0]});
        chk({tag, "_pc"}, dut.pc, m_pc);
    endtask

    task automatic restart(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        chk({tag, "_rst_res"}, {16'h0, result}, 32'h0);
        chk({tag, "_rst_pc"}, dut.pc, 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        m_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        #1;

        // Reset never asserted: the core must run from its initial state.
        clear_rom();
        m_rom[0] = e_i(12'd5, 5'd0, 3'd0, 5'd10, 7'h13);
        m_rom[1] = e_i(12'd7, 5'd10, 3'd0, 5'd10, 7'h13);
        commit_rom();
        chk("t1_time0", {16'h0, result}, 32'h0);
        step("t1");
        chk("t1_edge1", {16'h0, result}, 32'd5);
        step("t1");
        chk("t1_edge2", {16'h0, result}, 32'd12);

        clear_rom();
        m_rom[0] = e_i(12'hFFD, 5'd0, 3'd0, 5'd1, 7'h13);
        m_rom[1] = e_i(12'd4, 5'd0, 3'd0, 5'd2, 7'h13);
        m_rom[2] = e_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd10, 7'h33);
        m_rom[3] = e_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd10, 7'h33);
        m_rom[4] = e_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd10, 7'h33);
        m_rom[5] = e_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd10, 7'h33);
        commit_rom();
        restart("t2");
        repeat (3) step("t2");
        chk("t2_sub", {16'h0, result}, 32'h0007);
        step("t2");
        chk("t2_slt", {16'h0, result}, 32'h0001);
        step("t2");
        chk("t2_sltu", {16'h0, result}, 32'h0000);
        step("t2");
        chk("t2_sra", {16'h0, result}, 32'hFFFF);

        clear_rom();
        m_rom[0] = e_i(12'h055, 5'd0, 3'd0, 5'd1, 7'h13);
        m_rom[1] = e_s(12'd8, 5'd1, 5'd0, 3'd2);
        m_rom[2] = e_i(12'd8, 5'd0, 3'd2, 5'd10, 7'h03);
        m_rom[3] = e_i(12'd9, 5'd0, 3'd0, 5'd0, 7'h13);
        m_rom[4] = e_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd10, 7'h33);
        m_rom[5] = e_i(12'h108, 5'd0, 3'd2, 5'd10, 7'h03);
        commit_rom();
        restart("t3");
        repeat (3) step("t3");
        chk("t3_lw", {16'h0, result}, 32'h0055);
        repeat (2) step("t3");
        chk("t3_x0", {16'h0, result}, 32'h0000);
        step("t3");
        chk("t3_alias", {16'h0, result}, 32'h0055);

        clear_rom();
        m_rom[0] = e_i(12'd10, 5'd0, 3'd0, 5'd5, 7'h13);
        m_rom[1] = e_i(12'd0, 5'd0, 3'd0, 5'd10, 7'h13);
        m_rom[2] = e_i(12'd1, 5'd10, 3'd0, 5'd10, 7'h13);
        m_rom[3] = e_b(13'h1FFC, 5'd5, 5'd10, 3'd1);
        commit_rom();
        restart("t4");
        repeat (22) step("t4");
        chk("t4_loop_res", {16'h0, result}, 32'd10);
        chk("t4_loop_pc", dut.pc, 32'h10);

        clear_rom();
        m_rom[4]  = e_j(21'd8, 5'd10);
        m_rom[5]  = e_i(12'h077, 5'd0, 3'd0, 5'd10, 7'h13);
        m_rom[6]  = e_u(20'h12345, 5'd10, 7'h37);
        m_rom[7]  = e_i(12'h028, 5'd0, 3'd0, 5'd1, 7'h13);
        m_rom[8]  = e_i(12'd5, 5'd1, 3'd0, 5'd10, 7'h67);
        m_rom[9]  = e_i(12'd1, 5'd0, 3'd0, 5'd10, 7'h13);
        m_rom[10] = e_i(12'd2, 5'd0, 3'd0, 5'd10, 7'h13);
        m_rom[11] = e_u(20'h00001, 5'd10, 7'h17);
        commit_rom();
        restart("t5");
        repeat (5) step("t5");
        chk("t5_jal_rd", {16'h0, result}, 32'h0014);
        chk("t5_jal_pc", dut.pc, 32'h18);
        step("t5");
        chk("t5_lui", {16'h0, result}, 32'h5000);
        repeat (2) step("t5");
        chk("t5_jalr_rd", {16'h0, result}, 32'h0024);
        chk("t5_jalr_pc", dut.pc, 32'h2C);
        step("t5");
        chk("t5_auipc", {16'h0, result}, 32'h102C);

        clear_rom();
        m_rom[0] = e_i(12'd300, 5'd0, 3'd0, 5'd1, 7'h13);
        m_rom[1] = e_i(12'd300, 5'd0, 3'd0, 5'd2, 7'h13);
        m_rom[2] = e_i(12'h123, 5'd0, 3'd0, 5'd10, 7'h13);
        m_rom[3] = e_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd10, 7'h33);
        commit_rom();
        restart("mul");
        repeat (4) step("mul");
`ifdef RV_MUL_EN
        chk("mul_result", {16'h0, result}, 32'h5F90);
`else
        chk("mul_as_nop", {16'h0, result}, 32'h0123);
`endif

        // Random programs, including a mid-run reset that must restart execution from pc 0.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 64; i++) m_rom[i] = rnd_instr();
            commit_rom();
            restart("rnd");
            repeat (120) step("rnd");
        end
        for (int i = 0; i < 64; i++) m_rom[i] = rnd_instr();
        commit_rom();
        restart("mid");
        repeat (40) step("mid");
        restart("mid");
        repeat (40) step("mid");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
